// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus iterative
// shift-add MUL/MULHU and restoring DIVU/REMU, with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'h00);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'h01);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'h02);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'h03);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5'h04);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'h05);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(5'h06);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(5'h07);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'h08);
  localparam logic [OP_W-1:0] OP_SLE   = OP_W'(5'h09);
  localparam logic [OP_W-1:0] OP_SEQ   = OP_W'(5'h0A);
  localparam logic [OP_W-1:0] OP_SNE   = OP_W'(5'h0B);
  localparam logic [OP_W-1:0] OP_SGT   = OP_W'(5'h0C);
  localparam logic [OP_W-1:0] OP_SGE   = OP_W'(5'h0D);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'h0E);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(5'h10);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(5'h11);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(5'h12);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(5'h13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic is_multi(input logic [OP_W-1:0] f);
    return (f == OP_MUL) || (f == OP_MULHU) || (f == OP_DIVU) || (f == OP_REMU);
  endfunction

  function automatic logic [WIDTH-1:0] alu_single(input logic [OP_W-1:0]  f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [SH_W-1:0]         sh;
    logic signed [WIDTH-1:0] xs;
    logic [WIDTH-1:0]        r;
    sh = y[SH_W-1:0];
    xs = signed'(x);
    case (f)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_NOR:  r = ~(x | y);
      OP_SLT:  r = WIDTH'(x < y);
      OP_SLE:  r = WIDTH'(x <= y);
      OP_SEQ:  r = WIDTH'(x == y);
      OP_SNE:  r = WIDTH'(x != y);
      OP_SGT:  r = WIDTH'(x > y);
      OP_SGE:  r = WIDTH'(x >= y);
      OP_SRA:  r = $unsigned(xs >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t             state_q;
  logic [SH_W-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               dz_q;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   single_d;
  logic [WIDTH:0]     hi_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] step_d;
  logic [WIDTH-1:0]   fin_d;
  logic               fin_dz;
  logic               is_mul;
  logic               b_zero;
  logic               last_iter;

  // acc_q is {high, low}: for multiply {partial product, remaining multiplier},
  // for divide {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    single_d  = alu_single(op, a, b);
    is_mul    = (op_q == OP_MUL) || (op_q == OP_MULHU);
    b_zero    = (b_q == '0);
    last_iter = (cnt_q == SH_W'(WIDTH - 1));

    hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_ge   = (rem_sh >= {1'b0, b_q});

    if (is_mul) step_d = {hi_sum, acc_q[WIDTH-1:1]};
    else        step_d = {rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                          acc_q[WIDTH-2:0], rem_ge};

    fin_dz = 1'b0;
    case (op_q)
      OP_MUL:   fin_d = step_d[WIDTH-1:0];
      OP_MULHU: fin_d = step_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  begin fin_d = b_zero ? '1  : step_d[WIDTH-1:0];       fin_dz = b_zero; end
      OP_REMU:  begin fin_d = b_zero ? a_q : step_d[2*WIDTH-1:WIDTH]; fin_dz = b_zero; end
      default:  fin_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (is_multi(op)) begin
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end else begin
            result_q <= single_d;
            zero_q   <= (single_d == '0);
            dz_q     <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + SH_W'(1);
          if (last_iter) begin
            result_q <= fin_d;
            zero_q   <= (fin_d == '0);
            dz_q     <= fin_dz;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand/working registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) begin
      op_q  <= op;
      a_q   <= a;
      b_q   <= b;
      acc_q <= {{WIDTH{1'b0}}, ((op == OP_MUL) || (op == OP_MULHU)) ? b : a};
    end else if (state_q == S_BUSY) begin
      acc_q <= step_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed vectors with literal expectations plus
// a queue-based reference model checked every cycle out_valid is high.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;
  logic          div_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zr;
    logic         dz;
    int           lat;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  exp_t q[$];

  alu_mc #(.WIDTH(W), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Reference behaviour from plain arithmetic on wide integers.
  function automatic exp_t model(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned p;
    logic [4:0] sh;
    p  = 64'(x) * 64'(y);
    sh = y[4:0];
    e.dz  = 1'b0;
    e.lat = 1;
    case (f)
      5'h00: e.res = x + y;
      5'h01: e.res = x - y;
      5'h02: e.res = x & y;
      5'h03: e.res = x | y;
      5'h04: e.res = x ^ y;
      5'h05: e.res = x << sh;
      5'h06: e.res = x >> sh;
      5'h07: e.res = ~(x | y);
      5'h08: e.res = (x <  y) ? 1 : 0;
      5'h09: e.res = (x <= y) ? 1 : 0;
      5'h0A: e.res = (x == y) ? 1 : 0;
      5'h0B: e.res = (x != y) ? 1 : 0;
      5'h0C: e.res = (x >  y) ? 1 : 0;
      5'h0D: e.res = (x >= y) ? 1 : 0;
      5'h0E: e.res = $unsigned($signed(x) >>> sh);
      5'h10: begin e.res = p[31:0];  e.lat = W + 1; end
      5'h11: begin e.res = p[63:32]; e.lat = W + 1; end
      5'h12: begin e.res = (y == 0) ? '1 : x / y; e.dz = (y == 0); e.lat = W + 1; end
      5'h13: begin e.res = (y == 0) ? x  : x % y; e.dz = (y == 0); e.lat = W + 1; end
      default: e.res = '0;
    endcase
    e.zr      = (e.res == 0);
    e.acc_cyc = 0;
    e.seen    = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          timeout("unexpected out_valid");
        end else begin
          chk("model result", result, q[0].res);
          chk("model zero", W'(zero), W'(q[0].zr));
          chk("model div_zero", W'(div_zero), W'(q[0].dz));
          chk("in_ready in DONE", W'(in_ready), '0);
          if (!q[0].seen) begin
            chk("model latency", W'(cyc - q[0].acc_cyc + 1), W'(q[0].lat));
            q[0].seen = 1'b1;
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(op, a, b);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(posedge clk); #1;
    op = f; a = x; b = y; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 5'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) timeout(nm);
  endtask

  task automatic run_op(input string nm, input logic [4:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_r,
                        input int exp_lat, input logic exp_dz);
    int lat;
    issue(f, x, y);
    wait_valid(nm, lat);
    chk({nm, " result"}, result, exp_r);
    chk({nm, " latency"}, W'(lat), W'(exp_lat));
    chk({nm, " div_zero"}, W'(div_zero), W'(exp_dz));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", W'(in_ready), 1);
    chk("reset out_valid", W'(out_valid), 0);
    chk("reset result", result, 0);
    chk("reset zero", W'(zero), 0);
    chk("reset div_zero", W'(div_zero), 0);

    run_op("ADD wrap",  5'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0);
    chk("ADD wrap zero", W'(zero), 1);
    run_op("SUB",       5'h01, 32'h3, 32'h5, 32'hFFFFFFFE, 1, 0);
    run_op("AND",       5'h02, 32'hF0F0, 32'hFF00, 32'hF000, 1, 0);
    run_op("OR",        5'h03, 32'hF0F0, 32'hFF00, 32'hFFF0, 1, 0);
    run_op("XOR",       5'h04, 32'hF0F0, 32'hFF00, 32'h0FF0, 1, 0);
    run_op("SLL mask",  5'h05, 32'h1, 32'h21, 32'h2, 1, 0);
    run_op("SRL",       5'h06, 32'h80000000, 32'd31, 32'h1, 1, 0);
    run_op("NOR",       5'h07, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0);
    run_op("SLT uns",   5'h08, 32'h1, 32'hFFFFFFFF, 32'h1, 1, 0);
    run_op("SLE eq",    5'h09, 32'h5, 32'h5, 32'h1, 1, 0);
    run_op("SEQ",       5'h0A, 32'h5, 32'h6, 32'h0, 1, 0);
    run_op("SNE",       5'h0B, 32'h5, 32'h6, 32'h1, 1, 0);
    run_op("SGT uns",   5'h0C, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 0);
    run_op("SGE",       5'h0D, 32'h1, 32'h2, 32'h0, 1, 0);
    run_op("SRA",       5'h0E, 32'h80000000, 32'h4, 32'hF8000000, 1, 0);
    run_op("undef 0F",  5'h0F, 32'h7, 32'h7, 32'h0, 1, 0);
    run_op("undef 1F",  5'h1F, 32'h7, 32'h7, 32'h0, 1, 0);
    run_op("MUL",       5'h10, 32'h00010000, 32'h00010000, 32'h0, 33, 0);
    chk("MUL zero", W'(zero), 1);
    run_op("MULHU",     5'h11, 32'h00010000, 32'h00010000, 32'h1, 33, 0);
    run_op("MUL max",   5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 0);
    run_op("MULHU max", 5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("DIVU",      5'h12, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("REMU",      5'h13, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("DIVU b0",   5'h12, 32'd5, 32'd0, 32'hFFFFFFFF, 33, 1);
    run_op("REMU b0",   5'h13, 32'd5, 32'd0, 32'd5, 33, 1);
    run_op("DIVU by1",  5'h12, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 0);
    run_op("REMU big",  5'h13, 32'd7, 32'hFFFFFFFF, 32'd7, 33, 0);

    // Backpressure: DONE held, stray request ignored.
    out_ready = 1'b0;
    issue(5'h00, 32'd10, 32'd20);
    wait_valid("bp valid", lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 1);
      op = 5'h00; a = 32'd1; b = 32'd1;
      @(negedge clk);
      chk("bp out_valid", W'(out_valid), 1);
      chk("bp result", result, 32'd30);
      chk("bp in_ready", W'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp released out_valid", W'(out_valid), 0);
    chk("bp released in_ready", W'(in_ready), 1);

    // Reset in the middle of a divide.
    issue(5'h12, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", W'(out_valid), 0);
    chk("midrst result", result, 0);
    chk("midrst div_zero", W'(div_zero), 0);
    chk("midrst in_ready", W'(in_ready), 1);
    run_op("ADD after rst", 5'h00, 32'd2, 32'd3, 32'd5, 1, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
